decode_stage: RTL

- Instruction decode stage plus ID/EX pipeline register.
- Accepts a fetched instruction word and PC from fetch.
- Extracts opcode/funct7/funct3/register indices and generates the sign-extended immediate in the exact form the execute-stage ALU consumes.
- Registers all fields toward execute. Handles downstream stall, branch/jump flush and load-use hazard bubbles.

---
 rtl/decode_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32 decode stage and ID/EX pipeline register. Decodes fields and immediates,
// and inserts a single bubble on a load-use dependency by holding fetch off.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module decode_stage #(
    parameter int WORD_SIZE  = `WORD_SIZE,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [WORD_SIZE-1:0]  if_instr,
    input  logic [WORD_SIZE-1:0]  if_pc,
    output logic                  if_ready,
    input  logic                  ex_stall,
    input  logic                  flush,
    output logic                  id_valid,
    output logic [WORD_SIZE-1:0]  id_pc,
    output logic [6:0]            id_opcode,
    output logic [6:0]            id_funct7,
    output logic [2:0]            id_funct3,
    output logic [REG_ADDR_W-1:0] id_rs1,
    output logic [REG_ADDR_W-1:0] id_rs2,
    output logic [REG_ADDR_W-1:0] id_rd,
    output logic [WORD_SIZE-1:0]  id_immediate,
    output logic                  id_reg_write,
    output logic                  id_mem_read,
    output logic                  id_mem_write,
    output logic                  id_illegal
);
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JUMP    = 7'b1101111;

    typedef struct packed {
        logic                  valid;
        logic [WORD_SIZE-1:0]  pc;
        logic [6:0]            opcode;
        logic [6:0]            funct7;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_SIZE-1:0]  imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  illegal;
    } idex_t;

    logic [6:0]            op, f7_raw;
    logic [2:0]            f3_raw;
    logic [REG_ADDR_W-1:0] rd_raw, rs1_raw, rs2_raw;
    logic                  uses_rs1, uses_rs2, has_rd, has_f3, has_f7;
    logic                  is_load, is_store, legal, hazard;
    logic [31:0]           imm32;
    idex_t                 dec, idex_d, idex_q;

    assign op      = if_instr[6:0];
    assign f7_raw  = if_instr[31:25];
    assign f3_raw  = if_instr[14:12];
    assign rd_raw  = REG_ADDR_W'(if_instr[11:7]);
    assign rs1_raw = REG_ADDR_W'(if_instr[19:15]);
    assign rs2_raw = REG_ADDR_W'(if_instr[24:20]);

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        has_rd   = 1'b0;
        has_f3   = 1'b0;
        has_f7   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        legal    = 1'b0;
        imm32    = '0;
        case (op)
            OP_ALU: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_rd = 1'b1; has_f3 = 1'b1; has_f7 = 1'b1;
                legal = (f7_raw == 7'b0000000 && (f3_raw inside {3'b000, 3'b001, 3'b101, 3'b110, 3'b111}))
                     || ((f7_raw == 7'b0100000 || f7_raw == 7'b0000001) && f3_raw == 3'b000);
            end
            OP_ALU_IMM, OP_LOAD: begin
                uses_rs1 = 1'b1; has_rd = 1'b1; has_f3 = 1'b1;
                is_load  = (op == OP_LOAD);
                legal    = is_load ? (f3_raw == 3'b010) : (f3_raw == 3'b000);
                imm32    = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_f3 = 1'b1; is_store = 1'b1;
                legal    = (f3_raw == 3'b010);
                imm32    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OP_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_f3 = 1'b1;
                legal    = f3_raw inside {3'b000, 3'b001, 3'b100, 3'b101};
                imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                            if_instr[11:8], 1'b0};
            end
            OP_JUMP: begin
                has_rd = 1'b1; legal = 1'b1;
                imm32  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                          if_instr[30:21], 1'b0};
            end
            OP_AUIPC: begin
                has_rd = 1'b1; legal = 1'b1;
                imm32  = {if_instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase

        // Illegal encodings expose the raw fields so the trap handler sees them unmasked.
        dec           = '0;
        dec.valid     = 1'b1;
        dec.pc        = if_pc;
        dec.opcode    = op;
        dec.funct7    = (has_f7   || !legal) ? f7_raw  : '0;
        dec.funct3    = (has_f3   || !legal) ? f3_raw  : '0;
        dec.rs1       = (uses_rs1 || !legal) ? rs1_raw : '0;
        dec.rs2       = (uses_rs2 || !legal) ? rs2_raw : '0;
        dec.rd        = (has_rd   || !legal) ? rd_raw  : '0;
        dec.imm       = WORD_SIZE'($signed(imm32));
        dec.reg_write = legal && has_rd && (rd_raw != '0);
        dec.mem_read  = legal && is_load;
        dec.mem_write = legal && is_store;
        dec.illegal   = !legal;
    end

    // A bubble clears id_valid, so the same load cannot raise the hazard twice.
    assign hazard = if_valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != '0)
                 && ((uses_rs1 && rs1_raw == idex_q.rd) || (uses_rs2 && rs2_raw == idex_q.rd));
    assign if_ready = !ex_stall && !hazard;

    always_comb begin
        idex_d = idex_q;
        if (flush || (!ex_stall && hazard)) begin
            idex_d.valid     = 1'b0;
            idex_d.reg_write = 1'b0;
            idex_d.mem_read  = 1'b0;
            idex_d.mem_write = 1'b0;
            idex_d.illegal   = 1'b0;
        end else if (ex_stall) begin
            idex_d = idex_q;
        end else if (if_valid) begin
            idex_d = dec;
        end else begin
            idex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign id_valid     = idex_q.valid;
    assign id_pc        = idex_q.pc;
    assign id_opcode    = idex_q.opcode;
    assign id_funct7    = idex_q.funct7;
    assign id_funct3    = idex_q.funct3;
    assign id_rs1       = idex_q.rs1;
    assign id_rs2       = idex_q.rs2;
    assign id_rd        = idex_q.rd;
    assign id_immediate = idex_q.imm;
    assign id_reg_write = idex_q.reg_write;
    assign id_mem_read  = idex_q.mem_read;
    assign id_mem_write = idex_q.mem_write;
    assign id_illegal   = idex_q.illegal;
endmodule
